bitstream_decoder: RTL and testbench

Converts a unipolar stochastic bitstream back into a binary value by counting ones over a fixed window of 2^WIDTH valid samples. It sits on the output side of `network_control` as the inverse of the stream generators that feed the network. Each window is started by a one-cycle request and yields one registered result. The result is held under a valid/ready handshake until it is consumed.

---
 rtl/bitstream_pkg.sv | 13 +
 rtl/bitstream_counter.sv | 45 ++++
 rtl/bitstream_decoder.sv | 112 +++++++++++
 tb/tb_bitstream_decoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bitstream_pkg.sv
// Shared definitions for the stochastic bitstream generators and decoder:
// the decoder state encoding and the default window width.
package bitstream_pkg;

    localparam int unsigned BS_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_RESULT = 2'd2
    } bs_state_e;

endpackage

// File: rtl/bitstream_counter.sv
// Ones counter for one decode window: WIDTH+1 bits so a full window of ones
// is representable, with a saturated WIDTH-bit view of the next count.
module bitstream_counter
    import bitstream_pkg::*;
#(
    parameter int unsigned WIDTH = BS_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] sat_next_o
);

    logic [WIDTH:0] count_q;
    logic [WIDTH:0] count_d;

    // Next count; clear dominates enable so a new window always starts at zero
    always_comb begin
        count_d    = count_q;
        sat_next_o = '0;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
        if (count_d[WIDTH]) begin
            sat_next_o = '1;
        end else begin
            sat_next_o = count_d[WIDTH-1:0];
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bitstream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^WIDTH valid samples and
// presents the saturated count under a valid/ready handshake.
module bitstream_decoder
    import bitstream_pkg::*;
#(
    parameter int unsigned WIDTH = BS_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] value
);

    bs_state_e        state_q, state_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             busy_q, out_valid_q;
    logic             start_ok_s;
    logic             last_sample_s;
    logic             ones_en_s;
    logic [WIDTH-1:0] ones_sat_next_s;

    bitstream_counter #(.WIDTH(WIDTH)) u_ones (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (start_ok_s),
        .en_i       (ones_en_s),
        .sat_next_o (ones_sat_next_s)
    );

    // Next-state, sample counter and result capture
    always_comb begin
        state_d       = state_q;
        sample_d      = sample_q;
        value_d       = value_q;
        start_ok_s    = start && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_RESULT) && out_ready));
        last_sample_s = (state_q == ST_COUNT) && bit_valid && (sample_q == '1);
        ones_en_s     = (state_q == ST_COUNT) && bit_valid && bit_in;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (last_sample_s) begin
                    state_d = ST_RESULT;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_RESULT: begin
                if (out_ready && start) begin
                    state_d = ST_COUNT;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The Nth sample wraps the counter to zero exactly as the window closes
        if (start_ok_s) begin
            sample_d = '0;
        end else if ((state_q == ST_COUNT) && bit_valid) begin
            sample_d = sample_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            sample_d = sample_q;
        end

        if (last_sample_s) begin
            value_d = ones_sat_next_s;
        end else begin
            value_d = value_q;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sample_q    <= '0;
            value_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            value_q     <= value_d;
            busy_q      <= (state_d == ST_COUNT);
            out_valid_q <= (state_d == ST_RESULT);
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign value     = value_q;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed bench for bitstream_decoder (WIDTH=4): stimulus pushes expected
// results into a queue, a monitor pops them on each handshake.
module tb_bitstream_decoder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         bit_valid;
    logic         bit_in;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] value;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int exp_q[$];

    bitstream_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .value     (value)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n sample cycles; bit i of the masks gives bit_valid / bit_in
    task automatic feed(input int n, input logic [31:0] vmask,
                        input logic [31:0] bmask, output int busy_low);
        busy_low = 0;
        for (int i = 0; i < n; i++) begin
            bit_valid = vmask[i];
            bit_in    = bmask[i];
            if (!busy) busy_low++;
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic issue_start(input int expected);
        start = 1'b1;
        exp_q.push_back(expected);
        tick();
        start = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Scoreboard monitor: every transfer pops and checks one expected value
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result: got value %0d with empty queue", value);
            end else begin
                int e;
                e = exp_q.pop_front();
                pops++;
                if (int'(value) != e) begin
                    failures++;
                    $display("FAIL result_value: got %0d expected %0d", value, e);
                end
            end
        end
    end

    initial begin
        int bl;
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_value", value, 0);

        // Window 1: alternating 1010..., 8 ones; out_valid in cycle 17
        issue_start(8);
        check("w1_busy_after_start", busy, 1);
        feed(15, 32'hFFFF, 32'h5555, bl);
        check("w1_no_early_valid", out_valid, 0);
        feed(1, 32'h1, 32'h0, bl);
        check("w1_out_valid_cycle17", out_valid, 1);
        check("w1_busy_falls", busy, 0);
        consume();
        check("w1_valid_drops", out_valid, 0);
        check("w1_value_held_idle", value, 8);

        // Window 2: all ones saturates to 15 and holds without out_ready
        issue_start(15);
        feed(16, 32'hFFFF, 32'hFFFF, bl);
        for (int i = 0; i < 5; i++) begin
            check("w2_valid_held", out_valid, 1);
            check("w2_value_held", value, 15);
            tick();
        end
        consume();

        // Window 3: bit_valid toggling over 32 cycles, all ones
        issue_start(15);
        feed(31, 32'h55555555, 32'hFFFFFFFF, bl);
        check("w3_busy_low_cycles", bl, 0);
        check("w3_out_valid", out_valid, 1);
        check("w3_value", value, 15);

        // Window 4: back-to-back start on transfer, stray start mid-count ignored
        out_ready = 1'b1;
        issue_start(5);
        out_ready = 1'b0;
        check("w4_busy_b2b", busy, 1);
        check("w4_valid_low_b2b", out_valid, 0);
        feed(8, 32'hFF, 32'h1F, bl);
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
        tick();
        start = 1'b0;
        check("w4_start_ignored_busy", busy, 1);
        feed(6, 32'h3F, 32'h0, bl);
        check("w4_not_restarted_early", out_valid, 0);
        feed(1, 32'h1, 32'h0, bl);
        check("w4_complete_16", out_valid, 1);
        check("w4_value", value, 5);
        consume();

        // Window 5: reset after 7 ones discards the window; rst beats start
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(7, 32'h7F, 32'h7F, bl);
        rst = 1'b1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_value", value, 0);
        start = 1'b1;
        tick();
        check("rst_wins_over_start", busy, 0);
        rst = 1'b0; start = 1'b0;
        tick();

        // Window 6: full all-zero window after reset
        issue_start(0);
        feed(16, 32'hFFFF, 32'h0, bl);
        check("w6_out_valid", out_valid, 1);
        check("w6_value", value, 0);
        consume();

        tick();
        check("scoreboard_pops", pops, 5);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
